// File: rtl/excp_unit_pkg.sv
// Shared definitions for the MEM-stage exception arbiter: exception codes,
// CP0 register addresses, Status bit positions and FSM state encodings.
package excp_unit_pkg;

  localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
  localparam logic [31:0] EXC_INT     = 32'h0000_0004;
  localparam logic [31:0] EXC_SYSCALL = 32'h0000_0100;
  localparam logic [31:0] EXC_ERET    = 32'h0000_0200;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  localparam int STATUS_IE  = 0;
  localparam int STATUS_EXL = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_GUARD = 2'd2
  } excp_state_e;

endpackage

// File: rtl/excp_unit_intr_sync.sv
// Two-flop synchroniser for the external interrupt lines; reset clears both stages.
module excp_unit_intr_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] async_i,
  output logic [5:0] sync_o
);

  logic [5:0] meta_q;
  logic [5:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/excp_unit.sv
// MEM-stage exception arbiter feeding CP0: picks interrupt/syscall/eret, drives
// the pipeline flush and redirect PC, then holds off new exceptions for a guard window.
module excp_unit
  import excp_unit_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
  parameter int unsigned GUARD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic        mem_is_syscall,
  input  logic        mem_is_eret,
  input  logic        mem_cp0we,
  input  logic [4:0]  mem_cp0Addr,
  input  logic [31:0] mem_cp0wData,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_cause,
  input  logic [31:0] cp0_epc,
  input  logic [5:0]  intr_in,
  input  logic        intimer_in,
  output logic [5:0]  intr_out,
  output logic [31:0] excptype,
  output logic [31:0] excp_pc,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_req,
  output excp_state_e dbg_state_o
);

  excp_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic        flush_q, flush_d;

  logic [5:0]  intr_sync;
  logic [31:0] eff_status, eff_epc;
  logic [7:0]  eff_ip;
  logic        int_pend;
  logic [31:0] cand;
  logic        unused_bits;

  excp_unit_intr_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (intr_in),
    .sync_o  (intr_sync)
  );

  // The timer line is already in the clk domain, so it bypasses the synchroniser.
  assign intr_out = {intr_sync[5] | intimer_in, intr_sync[4:0]};

  // Forward an mtc0 in MEM so the decision sees the value CP0 is about to hold.
  always_comb begin
    eff_status = cp0_status;
    eff_epc    = cp0_epc;
    eff_ip     = cp0_cause[15:8];
    if (mem_cp0we && mem_cp0Addr == CP0_STATUS) eff_status = mem_cp0wData;
    if (mem_cp0we && mem_cp0Addr == CP0_EPC)    eff_epc    = mem_cp0wData;
    if (mem_cp0we && mem_cp0Addr == CP0_CAUSE)  eff_ip[1:0] = mem_cp0wData[9:8];
  end

  assign unused_bits = ^{eff_status[31:16], eff_status[7:2],
                         cp0_cause[31:16], cp0_cause[7:0]};

  assign int_pend = eff_status[STATUS_IE] & ~eff_status[STATUS_EXL] &
                    (|(eff_ip & eff_status[15:8]));

  always_comb begin
    cand = EXC_NONE;
    if (mem_valid) begin
      if (int_pend)            cand = EXC_INT;
      else if (mem_is_syscall) cand = EXC_SYSCALL;
      else if (mem_is_eret)    cand = EXC_ERET;
    end
  end

  assign excptype  = (!rst && state_q == ST_IDLE) ? cand : EXC_NONE;
  assign excp_pc   = mem_pc;
  assign stall_req = (state_q != ST_IDLE) && mem_valid && (mem_is_syscall || mem_is_eret);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    new_pc_d = new_pc_q;
    flush_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (excptype != EXC_NONE) begin
          state_d  = ST_FLUSH;
          flush_d  = 1'b1;
          new_pc_d = (excptype == EXC_ERET) ? eff_epc : EXC_VECTOR;
        end
      end
      ST_FLUSH: begin
        state_d = ST_GUARD;
        cnt_d   = 4'(GUARD_CYCLES - 1);
      end
      ST_GUARD: begin
        if (cnt_q == 4'd0) state_d = ST_IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      new_pc_q <= '0;
      flush_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      new_pc_q <= new_pc_d;
      flush_q  <= flush_d;
    end
  end

  assign flush       = flush_q;
  assign new_pc      = new_pc_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_excp_unit.sv
// Bench for excp_unit: table of single-instruction cases plus hand sequences
// for synchroniser latency, deferral during the guard window and reset mid-flush.
module tb_excp_unit;
  import excp_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_is_syscall, mem_is_eret, mem_cp0we, intimer_in;
  logic [31:0] mem_pc, mem_cp0wData, cp0_status, cp0_cause, cp0_epc;
  logic [4:0]  mem_cp0Addr;
  logic [5:0]  intr_in, intr_out;
  logic [31:0] excptype, excp_pc, new_pc;
  logic        flush, stall_req;
  excp_state_e dbg_state;

  logic [31:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic        sys;
    logic        eret;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic [31:0] exp_type;
    logic [31:0] exp_npc;
  } vec_t;

  vec_t vecs[12];

  excp_unit dut (
    .clk            (clk),
    .rst            (rst),
    .mem_valid      (mem_valid),
    .mem_pc         (mem_pc),
    .mem_is_syscall (mem_is_syscall),
    .mem_is_eret    (mem_is_eret),
    .mem_cp0we      (mem_cp0we),
    .mem_cp0Addr    (mem_cp0Addr),
    .mem_cp0wData   (mem_cp0wData),
    .cp0_status     (cp0_status),
    .cp0_cause      (cp0_cause),
    .cp0_epc        (cp0_epc),
    .intr_in        (intr_in),
    .intimer_in     (intimer_in),
    .intr_out       (intr_out),
    .excptype       (excptype),
    .excp_pc        (excp_pc),
    .flush          (flush),
    .new_pc         (new_pc),
    .stall_req      (stall_req),
    .dbg_state_o    (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_valid      = 1'b0;
    mem_pc         = '0;
    mem_is_syscall = 1'b0;
    mem_is_eret    = 1'b0;
    mem_cp0we      = 1'b0;
    mem_cp0Addr    = '0;
    mem_cp0wData   = '0;
    cp0_status     = '0;
    cp0_cause      = '0;
    cp0_epc        = '0;
    intr_in        = '0;
    intimer_in     = 1'b0;
  endtask

  task automatic drive_vec(input vec_t v);
    mem_valid      = v.valid;
    mem_pc         = v.pc;
    mem_is_syscall = v.sys;
    mem_is_eret    = v.eret;
    mem_cp0we      = v.we;
    mem_cp0Addr    = v.addr;
    mem_cp0wData   = v.wdata;
    cp0_status     = v.status;
    cp0_cause      = v.cause;
    cp0_epc        = v.epc;
  endtask

  // scoreboard
  task automatic push_exp(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act);
    logic [31:0] e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: got %h but no expected value was queued", name, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", name, act, e);
      end
    end
  endtask

  initial begin
    //             valid pc           sys   eret  we    addr        wdata        status       cause        epc          type         new_pc
    vecs[0]  = '{1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 5'd0,       32'h0,       32'h401,     32'h400,     32'h0,       EXC_INT,     32'h20};
    vecs[1]  = '{1'b1, 32'h40,  1'b1, 1'b0, 1'b0, 5'd0,       32'h0,       32'h0,       32'h0,       32'h0,       EXC_SYSCALL, 32'h20};
    vecs[2]  = '{1'b1, 32'h48,  1'b0, 1'b1, 1'b0, 5'd0,       32'h0,       32'h0,       32'h0,       32'h44,      EXC_ERET,    32'h44};
    vecs[3]  = '{1'b1, 32'h50,  1'b0, 1'b0, 1'b1, CP0_STATUS, 32'h0,       32'h401,     32'h400,     32'h0,       EXC_NONE,    32'h0};
    vecs[4]  = '{1'b0, 32'h54,  1'b1, 1'b0, 1'b0, 5'd0,       32'h0,       32'h401,     32'h400,     32'h0,       EXC_NONE,    32'h0};
    vecs[5]  = '{1'b1, 32'h58,  1'b1, 1'b0, 1'b0, 5'd0,       32'h0,       32'h801,     32'h800,     32'h0,       EXC_INT,     32'h20};
    vecs[6]  = '{1'b1, 32'h5c,  1'b0, 1'b1, 1'b1, CP0_EPC,    32'h88,      32'h0,       32'h0,       32'h44,      EXC_ERET,    32'h88};
    vecs[7]  = '{1'b1, 32'h60,  1'b0, 1'b0, 1'b0, 5'd0,       32'h0,       32'h403,     32'h400,     32'h0,       EXC_NONE,    32'h0};
    vecs[8]  = '{1'b1, 32'h64,  1'b0, 1'b0, 1'b1, CP0_CAUSE,  32'h100,     32'h101,     32'h0,       32'h0,       EXC_INT,     32'h20};
    vecs[9]  = '{1'b1, 32'h68,  1'b0, 1'b0, 1'b1, CP0_CAUSE,  32'h400,     32'h401,     32'h0,       32'h0,       EXC_NONE,    32'h0};
    vecs[10] = '{1'b1, 32'h6c,  1'b0, 1'b0, 1'b1, CP0_STATUS, 32'h401,     32'h0,       32'h400,     32'h0,       EXC_INT,     32'h20};
    vecs[11] = '{1'b1, 32'h70,  1'b1, 1'b0, 1'b0, 5'd0,       32'h0,       32'h400,     32'h400,     32'h0,       EXC_SYSCALL, 32'h20};

    idle_inputs();
    rst = 1'b1;
    mem_valid = 1'b1;
    mem_is_syscall = 1'b1;
    repeat (3) tick();

    // reset state, with a syscall presented while rst is high
    push_exp(32'h0); check("reset_excptype", excptype);
    push_exp(32'h0); check("reset_flush", 32'(flush));
    push_exp(32'h0); check("reset_new_pc", new_pc);
    push_exp(32'h0); check("reset_intr_out", 32'(intr_out));
    push_exp(32'(ST_IDLE)); check("reset_state", 32'(dbg_state));
    idle_inputs();
    rst = 1'b0;
    tick();

    // synchroniser latency and timer merge
    intr_in = 6'b000100;
    tick();
    push_exp(32'h0); check("sync_after_1_edge", 32'(intr_out));
    tick();
    push_exp(32'h4); check("sync_after_2_edges", 32'(intr_out));
    intimer_in = 1'b1;
    #1;
    push_exp(32'h24); check("sync_timer_merge", 32'(intr_out));
    intimer_in = 1'b0;
    intr_in = '0;
    rst = 1'b1;
    tick();
    push_exp(32'h0); check("sync_cleared_by_rst", 32'(intr_out));
    rst = 1'b0;
    tick();

    // table-driven single-instruction cases
    for (int i = 0; i < 12; i++) begin
      drive_vec(vecs[i]);
      push_exp(vecs[i].exp_type); push_exp(vecs[i].pc);
      #1;
      check($sformatf("v%0d_excptype", i), excptype);
      check($sformatf("v%0d_excp_pc", i), excp_pc);
      tick();
      idle_inputs();
      #1;
      push_exp(32'(vecs[i].exp_type != EXC_NONE));
      check($sformatf("v%0d_flush", i), 32'(flush));
      if (vecs[i].exp_type != EXC_NONE) begin
        push_exp(vecs[i].exp_npc);
        check($sformatf("v%0d_new_pc", i), new_pc);
        tick();
        push_exp(32'h0); check($sformatf("v%0d_flush_1cyc", i), 32'(flush));
        push_exp(32'(ST_GUARD)); check($sformatf("v%0d_guard1", i), 32'(dbg_state));
        tick();
        push_exp(32'(ST_GUARD)); check($sformatf("v%0d_guard2", i), 32'(dbg_state));
        tick();
      end
      push_exp(32'(ST_IDLE)); check($sformatf("v%0d_idle", i), 32'(dbg_state));
      repeat ($urandom_range(0, 2)) tick();
    end

    // syscall held while the previous exception is flushing/guarding
    drive_vec(vecs[1]);
    tick();
    mem_pc = 32'h60;
    #1;
    push_exp(32'h1); check("defer_stall_flush", 32'(stall_req));
    push_exp(32'h0); check("defer_type_flush", excptype);
    tick();
    push_exp(32'h1); check("defer_stall_guard1", 32'(stall_req));
    push_exp(32'h0); check("defer_type_guard1", excptype);
    tick();
    push_exp(32'h1); check("defer_stall_guard2", 32'(stall_req));
    push_exp(32'h0); check("defer_flush_guard2", 32'(flush));
    tick();
    push_exp(32'h0); check("defer_stall_idle", 32'(stall_req));
    push_exp(EXC_SYSCALL); check("defer_type_idle", excptype);
    push_exp(32'h60); check("defer_pc_idle", excp_pc);
    tick();
    push_exp(32'h1); check("defer_flush", 32'(flush));
    push_exp(32'h20); check("defer_new_pc", new_pc);
    push_exp(32'h0); check("defer_type_once", excptype);
    idle_inputs();
    repeat (3) tick();
    push_exp(32'(ST_IDLE)); check("defer_back_idle", 32'(dbg_state));

    // reset while in FLUSH aborts the sequence
    drive_vec(vecs[1]);
    tick();
    idle_inputs();
    push_exp(32'h1); check("rstflush_flush_before", 32'(flush));
    rst = 1'b1;
    tick();
    push_exp(32'h0); check("rstflush_flush", 32'(flush));
    push_exp(32'(ST_IDLE)); check("rstflush_state", 32'(dbg_state));
    push_exp(32'h0); check("rstflush_new_pc", new_pc);
    rst = 1'b0;
    tick();
    tick();
    push_exp(32'h0); check("rstflush_no_pulse", 32'(flush));
    push_exp(32'(ST_IDLE)); check("rstflush_still_idle", 32'(dbg_state));

    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expected values left, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
